// File: rtl/note_sequencer_if.sv
// ---------------------------------------------------------------------------
// note_sequencer_if
//   Bundles the control pulses, the synchronous note-ROM port and the tone
//   generator outputs of note_sequencer. clk and reset stay plain ports on
//   the design itself.
//
//   Signals
//     tick      controller -> seq  one-cycle beat pulse
//     start     controller -> seq  one-cycle pulse, begin song at address 0
//     stop      controller -> seq  one-cycle pulse, abort playback
//     pause     controller -> seq  level, hold current note and silence it
//     rom_data  ROM -> seq         {tone, dur}, valid one cycle after rom_addr
//     rom_addr  seq -> ROM         note ROM address
//     tone_div  seq -> tone gen    half-period divisor (0 = rest)
//     tone_en   seq -> tone gen    tone generator enable
//     busy      seq -> controller  high whenever the sequencer is not idle
//     done      seq -> controller  one-cycle pulse at the end of a song
//
//   Modports
//     master : the controller / ROM / tone-generator side
//     slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface note_sequencer_if #(
  parameter int ADDR_W = 6,
  parameter int TONE_W = 16,
  parameter int DUR_W  = 4
) ();

  logic                    tick;
  logic                    start;
  logic                    stop;
  logic                    pause;
  logic [ADDR_W-1:0]       rom_addr;
  logic [TONE_W+DUR_W-1:0] rom_data;
  logic [TONE_W-1:0]       tone_div;
  logic                    tone_en;
  logic                    busy;
  logic                    done;

  modport master (
    output tick, start, stop, pause, rom_data,
    input  rom_addr, tone_div, tone_en, busy, done
  );

  modport slave (
    input  tick, start, stop, pause, rom_data,
    output rom_addr, tone_div, tone_en, busy, done
  );

endinterface

// File: rtl/note_sequencer.sv
// ---------------------------------------------------------------------------
// note_sequencer
//   Walks a synchronous note ROM of {tone, dur} entries and drives a tone
//   generator. Each note is held for dur beat ticks; an entry with dur == 0
//   marks the end of the song. With LOOP = 1 the song restarts at address 0
//   instead of finishing.
//
//   Ports
//     clk        system clock, all logic on posedge
//     reset      synchronous active-high reset
//     bus        note_sequencer_if.slave (pulses, ROM port, tone outputs)
//     dbg_state  current FSM state (0 IDLE, 1 FETCH, 2 LOAD, 3 PLAY)
//
//   Control protocol: start, stop and tick are single-cycle pulses sampled
//   on the rising clock edge; there is no back-pressure. start is honoured
//   only in IDLE, stop only outside IDLE, and stop beats start when both are
//   high. pause is a level: beat ticks arriving while it is high are lost,
//   not remembered. busy and done are registered and change on the same edge
//   as the state they describe.
// ---------------------------------------------------------------------------
module note_sequencer #(
  parameter int ADDR_W = 6,
  parameter int TONE_W = 16,
  parameter int DUR_W  = 4,
  parameter int LOOP   = 0
) (
  input  logic                clk,
  input  logic                reset,
  note_sequencer_if.slave     bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_PLAY  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [TONE_W-1:0]   tone_div_q, tone_div_d;
  logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
  logic                tone_en_q, tone_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [TONE_W-1:0]   rom_tone;
  logic [DUR_W-1:0]    rom_dur;
  logic                beat;

  assign rom_tone = bus.rom_data[TONE_W+DUR_W-1:DUR_W];
  assign rom_dur  = bus.rom_data[DUR_W-1:0];

  // Only unpaused ticks advance a note; paused ticks are simply dropped.
  assign beat = bus.tick & ~bus.pause;

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    tone_div_d = tone_div_q;
    dur_cnt_d  = dur_cnt_q;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          rom_addr_d = '0;
          state_d    = ST_FETCH;
        end
      end

      // rom_addr is stable for this cycle; the synchronous ROM answers in LOAD.
      ST_FETCH: begin
        state_d = ST_LOAD;
      end

      ST_LOAD: begin
        if (rom_dur == '0) begin
          rom_addr_d = '0;
          if (LOOP != 0) begin
            state_d = ST_FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          tone_div_d = rom_tone;
          dur_cnt_d  = rom_dur;
          state_d    = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (beat) begin
          dur_cnt_d = dur_cnt_q - DUR_W'(1);
          if (dur_cnt_q == DUR_W'(1)) begin
            // Address arithmetic wraps naturally at 2^ADDR_W.
            rom_addr_d = rom_addr_q + ADDR_W'(1);
            state_d    = ST_FETCH;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // stop overrides whatever the state logic above decided.
    if (bus.stop && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      rom_addr_d = '0;
      done_d     = 1'b0;
    end

    // Registered status derived from the next state so it lines up with it.
    busy_d    = (state_d != ST_IDLE);
    tone_en_d = (state_d == ST_PLAY) && !bus.pause && (tone_div_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= '0;
      tone_div_q <= '0;
      dur_cnt_q  <= '0;
      tone_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      tone_div_q <= tone_div_d;
      dur_cnt_q  <= dur_cnt_d;
      tone_en_q  <= tone_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.tone_div = tone_div_q;
  assign bus.tone_en  = tone_en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// ---------------------------------------------------------------------------
// tb_note_sequencer
//   Three sequencer instances share clock, reset and beat tick:
//     id 0 : ADDR_W=6, LOOP=0   (basic song, rest, pause, stop cases)
//     id 1 : ADDR_W=6, LOOP=1   (looping song)
//     id 2 : ADDR_W=2, LOOP=0   (address wrap, reset mid-note)
//   A monitor summarises every played note (id, address, tone, ticks seen
//   while in PLAY, tone_en seen, tone_en while paused) and every done pulse,
//   and checks each against the expected queue filled by the stimulus.
// ---------------------------------------------------------------------------
module tb_note_sequencer;

  localparam int DW = 20;
  localparam int W  = 36;
  localparam logic [1:0] K_NOTE  = 2'd1;
  localparam logic [1:0] K_DONE  = 2'd2;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  note_sequencer_if #(.ADDR_W(6), .TONE_W(16), .DUR_W(4)) if0 ();
  note_sequencer_if #(.ADDR_W(6), .TONE_W(16), .DUR_W(4)) if1 ();
  note_sequencer_if #(.ADDR_W(2), .TONE_W(16), .DUR_W(4)) if2 ();
  logic [1:0] dbg0, dbg1, dbg2;

  note_sequencer #(.ADDR_W(6), .TONE_W(16), .DUR_W(4), .LOOP(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(if0), .dbg_state(dbg0));
  note_sequencer #(.ADDR_W(6), .TONE_W(16), .DUR_W(4), .LOOP(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1), .dbg_state(dbg1));
  note_sequencer #(.ADDR_W(2), .TONE_W(16), .DUR_W(4), .LOOP(0)) u_dut2 (
    .clk(clk), .reset(reset), .bus(if2), .dbg_state(dbg2));

  // Synchronous ROM models
  logic [DW-1:0] rom0 [64];
  logic [DW-1:0] rom1 [64];
  logic [DW-1:0] rom2 [4];

  always @(posedge clk) begin
    if0.rom_data <= rom0[if0.rom_addr];
    if1.rom_data <= rom1[if1.rom_addr];
    if2.rom_data <= rom2[if2.rom_addr];
  end

  // Free-running beat: one-cycle pulse every 8 clocks
  logic tick_s = 1'b0;
  int   tick_cnt = 0;
  assign if0.tick = tick_s;
  assign if1.tick = tick_s;
  assign if2.tick = tick_s;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tick_cnt = (tick_cnt == 7) ? 0 : tick_cnt + 1;
      tick_s   = (tick_cnt == 7);
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int  tests    = 0;
  int  fails    = 0;
  int  en_bad   = 0;
  int  busy_bad = 0;
  bit  mon_on   = 1'b0;

  logic [1:0]  m_prev_st [3];
  logic        m_pz_prev [3];
  logic [5:0]  m_addr    [3];
  logic [15:0] m_tone    [3];
  logic [7:0]  m_ticks   [3];
  logic        m_en      [3];
  logic        m_enp     [3];

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rec(input string name, input logic [W-1:0] act);
    logic [W-1:0] exp;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: got %h but no event expected", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        fails++;
        $display("FAIL %s: got %h expected %h", name, act, exp);
      end
    end
  endtask

  task automatic exp_note(input int id, input logic [5:0] addr, input logic [15:0] tone,
                          input logic [7:0] ticks, input logic en);
    exp_q.push_back({K_NOTE, 2'(id), addr, tone, ticks, en, 1'b0});
  endtask

  task automatic exp_done(input int id);
    exp_q.push_back({K_DONE, 2'(id), 6'd0, 16'h0, 8'h0, 2'b00});
  endtask

  task automatic mon_step(input int id, input logic [1:0] st, input logic [5:0] addr,
                          input logic [15:0] tdiv, input logic en, input logic bsy,
                          input logic dn, input logic pz, input logic tk);
    if (st == S_PLAY && m_prev_st[id] != S_PLAY) begin
      m_addr[id]  = addr;
      m_tone[id]  = tdiv;
      m_ticks[id] = 8'd0;
      m_en[id]    = 1'b0;
      m_enp[id]   = 1'b0;
    end
    if (st == S_PLAY) begin
      if (tk) m_ticks[id] = m_ticks[id] + 8'd1;
      m_en[id]  = m_en[id] | en;
      m_enp[id] = m_enp[id] | (en & m_pz_prev[id]);
    end
    if (st != S_PLAY && m_prev_st[id] == S_PLAY)
      check_rec("note", {K_NOTE, 2'(id), m_addr[id], m_tone[id], m_ticks[id], m_en[id], m_enp[id]});
    if (dn)
      check_rec("done", {K_DONE, 2'(id), addr, 16'h0, 8'h0, 2'b00});
    if (en && (st != S_PLAY || tdiv == 16'h0)) en_bad++;
    if (bsy != (st != S_IDLE)) busy_bad++;
    m_prev_st[id] = st;
    m_pz_prev[id] = pz;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      mon_step(0, dbg0, if0.rom_addr, if0.tone_div, if0.tone_en, if0.busy, if0.done, if0.pause, tick_s);
      mon_step(1, dbg1, if1.rom_addr, if1.tone_div, if1.tone_en, if1.busy, if1.done, if1.pause, tick_s);
      mon_step(2, dbg2, {4'b0, if2.rom_addr}, if2.tone_div, if2.tone_en, if2.busy, if2.done,
               if2.pause, tick_s);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [1:0] dbg_of(input int id);
    case (id)
      0:       return dbg0;
      1:       return dbg1;
      default: return dbg2;
    endcase
  endfunction

  task automatic set_ss(input int id, input logic s, input logic p);
    case (id)
      0:       begin if0.start = s; if0.stop = p; end
      1:       begin if1.start = s; if1.stop = p; end
      default: begin if2.start = s; if2.stop = p; end
    endcase
  endtask

  task automatic set_pause(input int id, input logic pz);
    case (id)
      0:       if0.pause = pz;
      1:       if1.pause = pz;
      default: if2.pause = pz;
    endcase
  endtask

  // Called at posedge+2; holds the pulse for exactly one sampling edge.
  task automatic pulse(input int id, input logic s, input logic p);
    set_ss(id, s, p);
    @(posedge clk); #2;
    set_ss(id, 1'b0, 1'b0);
  endtask

  task automatic wait_tick(input int budget);
    int n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!tick_s && n < budget);
    if (!tick_s) check_val("tick_timeout", 32'(tick_s), 32'd1);
  endtask

  task automatic wait_state(input int id, input logic [1:0] st, input int budget);
    int n = 0;
    while (dbg_of(id) != st && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    if (dbg_of(id) != st) check_val("state_timeout", 32'(dbg_of(id)), 32'(st));
  endtask

  task automatic wait_qsize(input int target, input int budget);
    int n = 0;
    while (exp_q.size() > target && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    if (exp_q.size() > target) check_val("queue_timeout", 32'(exp_q.size()), 32'(target));
  endtask

  task automatic check_idle(input int id, input string name, input bit chk_div);
    logic [5:0]  a;
    logic [15:0] d;
    logic        e, b, dn;
    case (id)
      0:       begin a = if0.rom_addr; d = if0.tone_div; e = if0.tone_en; b = if0.busy; dn = if0.done; end
      1:       begin a = if1.rom_addr; d = if1.tone_div; e = if1.tone_en; b = if1.busy; dn = if1.done; end
      default: begin a = {4'b0, if2.rom_addr}; d = if2.tone_div; e = if2.tone_en; b = if2.busy; dn = if2.done; end
    endcase
    check_val({name, "_state"},    32'(dbg_of(id)), 32'(S_IDLE));
    check_val({name, "_rom_addr"}, 32'(a), 32'd0);
    check_val({name, "_tone_en"},  32'(e), 32'd0);
    check_val({name, "_busy"},     32'(b), 32'd0);
    check_val({name, "_done"},     32'(dn), 32'd0);
    if (chk_div) check_val({name, "_tone_div"}, 32'(d), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int busy_seen;
    for (int i = 0; i < 64; i++) begin rom0[i] = '0; rom1[i] = '0; end
    for (int i = 0; i < 4; i++) rom2[i] = '0;
    for (int i = 0; i < 3; i++) begin
      m_prev_st[i] = S_IDLE; m_pz_prev[i] = 1'b0; m_addr[i] = '0;
      m_tone[i] = '0; m_ticks[i] = '0; m_en[i] = 1'b0; m_enp[i] = 1'b0;
      set_ss(i, 1'b0, 1'b0);
      set_pause(i, 1'b0);
    end

    // Reset values, with start held high to show it is ignored in reset
    reset = 1'b1;
    set_ss(0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check_idle(0, "rst0", 1'b1);
    check_idle(1, "rst1", 1'b1);
    check_idle(2, "rst2", 1'b1);
    set_ss(0, 1'b0, 1'b0);
    reset  = 1'b0;
    mon_on = 1'b1;

    // Two-note song, LOOP=0
    rom0[0] = {16'h0100, 4'd2};
    rom0[1] = {16'h0080, 4'd1};
    rom0[2] = {16'h0000, 4'd0};
    exp_note(0, 6'd0, 16'h0100, 8'd2, 1'b1);
    exp_note(0, 6'd1, 16'h0080, 8'd1, 1'b1);
    exp_done(0);
    pulse(0, 1'b1, 1'b0);
    wait_qsize(0, 500);
    wait_state(0, S_IDLE, 50);
    check_idle(0, "song_end", 1'b0);

    // Same song, LOOP=1: replays, never finishes; stopped between notes
    rom1[0] = {16'h0100, 4'd2};
    rom1[1] = {16'h0080, 4'd1};
    rom1[2] = {16'h0000, 4'd0};
    exp_note(1, 6'd0, 16'h0100, 8'd2, 1'b1);
    exp_note(1, 6'd1, 16'h0080, 8'd1, 1'b1);
    exp_note(1, 6'd0, 16'h0100, 8'd2, 1'b1);
    exp_note(1, 6'd1, 16'h0080, 8'd1, 1'b1);
    pulse(1, 1'b1, 1'b0);
    wait_qsize(0, 1000);
    pulse(1, 1'b0, 1'b1);
    wait_state(1, S_IDLE, 20);
    check_idle(1, "loop_stop", 1'b0);

    // Rest note: tone 0 for 3 ticks, tone_en never high
    rom0[0] = {16'h0000, 4'd3};
    rom0[1] = {16'h0000, 4'd0};
    exp_note(0, 6'd0, 16'h0000, 8'd3, 1'b0);
    exp_done(0);
    pulse(0, 1'b1, 1'b0);
    wait_qsize(0, 500);
    wait_state(0, S_IDLE, 50);

    // Pause across two ticks of a dur=3 note: five ticks in PLAY
    rom0[0] = {16'h0200, 4'd3};
    rom0[1] = {16'h0000, 4'd0};
    exp_note(0, 6'd0, 16'h0200, 8'd5, 1'b1);
    exp_done(0);
    wait_tick(20);
    pulse(0, 1'b1, 1'b0);
    wait_state(0, S_PLAY, 20);
    wait_tick(20);
    @(posedge clk); #2;
    set_pause(0, 1'b1);
    wait_tick(20);
    wait_tick(20);
    @(posedge clk); #2;
    set_pause(0, 1'b0);
    wait_qsize(0, 500);
    wait_state(0, S_IDLE, 50);

    // stop one tick into a dur=4 note: no done pulse
    rom0[0] = {16'h0300, 4'd4};
    rom0[1] = {16'h0000, 4'd0};
    exp_note(0, 6'd0, 16'h0300, 8'd1, 1'b1);
    wait_tick(20);
    pulse(0, 1'b1, 1'b0);
    wait_state(0, S_PLAY, 20);
    wait_tick(20);
    @(posedge clk); #2;
    pulse(0, 1'b0, 1'b1);
    check_idle(0, "stop_play", 1'b0);
    wait_qsize(0, 20);

    // start and stop together in IDLE: busy never rises
    pulse(0, 1'b1, 1'b1);
    busy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (if0.busy) busy_seen++;
      @(posedge clk); #2;
    end
    check_val("start_stop_busy", 32'(busy_seen), 32'd0);
    check_idle(0, "start_stop", 1'b0);

    // ADDR_W=2 wrap 0,1,2,3,0 then reset in the middle of the next note
    rom2[0] = {16'h0010, 4'd1};
    rom2[1] = {16'h0020, 4'd1};
    rom2[2] = {16'h0030, 4'd1};
    rom2[3] = {16'h0040, 4'd1};
    exp_note(2, 6'd0, 16'h0010, 8'd1, 1'b1);
    exp_note(2, 6'd1, 16'h0020, 8'd1, 1'b1);
    exp_note(2, 6'd2, 16'h0030, 8'd1, 1'b1);
    exp_note(2, 6'd3, 16'h0040, 8'd1, 1'b1);
    exp_note(2, 6'd0, 16'h0010, 8'd1, 1'b1);
    exp_note(2, 6'd1, 16'h0020, 8'd0, 1'b1);
    wait_tick(20);
    pulse(2, 1'b1, 1'b0);
    wait_qsize(1, 1000);
    wait_state(2, S_PLAY, 20);
    reset = 1'b1;
    @(posedge clk); #2;
    check_idle(2, "rst_play", 1'b1);
    reset = 1'b0;
    wait_qsize(0, 20);

    // Final report
    repeat (4) @(posedge clk);
    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    check_val("tone_en_outside_play", 32'(en_bad), 32'd0);
    check_val("busy_vs_state", 32'(busy_bad), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
